// File: rtl/mac16_dot_seq_pkg.sv
// Shared types and limits for the MAC16 dot-product sequencer.
package mac16_dot_seq_pkg;

    localparam int MAC_LAT_MAX = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ACC,
        DRAIN,
        RES
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        LOAD,
        BEAT
    } tok_t;

    function automatic bit mac_lat_ok(input int lat);
        return (lat >= 0) && (lat <= MAC_LAT_MAX);
    endfunction

endpackage

// File: rtl/mac16_tok_pipe.sv
// Token shift register that lines LOAD/BEAT markers up with the operands
// reaching the tile's accumulator input; the last stage drives OLOAD/OHOLD.
module mac16_tok_pipe
    import mac16_dot_seq_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] tok_in,
    output logic       mac_oload,
    output logic       mac_ohold
);

    tok_t stage [DEPTH];

    // NOTE: every stage is reset, because a stale token would load or advance the accumulator.
    // NOTE: non-blocking assignments make the shift independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= NONE;
            end
        end else begin
            stage[0] <= tok_t'(tok_in);
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign mac_oload = (stage[DEPTH-1] == LOAD);
    assign mac_ohold = (stage[DEPTH-1] == NONE);

endmodule

// File: rtl/mac16_dot_seq.sv
// Streaming dot-product sequencer feeding one MAC16 tile in 16x16 MAC mode;
// clears the accumulator, streams operand pairs, then captures the tile output.
module mac16_dot_seq
    import mac16_dot_seq_pkg::*;
#(
    parameter int LEN_W   = 12,
    parameter int MAC_LAT = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [15:0]      s_a,
    input  logic [15:0]      s_b,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [31:0]      r_data,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    output logic             mac_oload,
    output logic             mac_ohold,
    input  logic [31:0]      mac_o
);

    if (!mac_lat_ok(MAC_LAT)) begin : g_bad_mac_lat
        $error("mac16_dot_seq: MAC_LAT must be within 0..%0d", MAC_LAT_MAX);
    end

    // DRAIN spans the token pipe plus the accumulator register: MAC_LAT+2 cycles.
    localparam logic [2:0] DRAIN_LAST = 3'(MAC_LAT + 1);

    state_t           state;
    state_t           state_nx;
    tok_t             tok_in;
    logic [LEN_W-1:0] rem;
    logic [2:0]       drain_cnt;
    logic             drain_last;

    assign drain_last = (drain_cnt == DRAIN_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        tok_in    = NONE;
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        r_valid   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = CLR;
            end
            CLR: begin
                tok_in   = LOAD;
                state_nx = (rem != '0) ? ACC : DRAIN;
            end
            ACC: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    tok_in = BEAT;
                    if (rem == LEN_W'(1)) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_last) state_nx = RES;
            end
            RES: begin
                r_valid = 1'b1;
                if (r_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rem       <= '0;
            drain_cnt <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            r_data    <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                rem <= cmd_len;
            end
            if (state == ACC && s_valid) begin
                mac_a <= s_a;
                mac_b <= s_b;
                rem   <= rem - LEN_W'(1);
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_last ? 3'd0 : drain_cnt + 3'd1;
                if (drain_last) r_data <= mac_o;
            end
        end
    end

    mac16_tok_pipe #(
        .DEPTH (1 + MAC_LAT)
    ) u_tok_pipe (
        .clk       (CLK),
        .rst       (RST),
        .tok_in    (tok_in),
        .mac_oload (mac_oload),
        .mac_ohold (mac_ohold)
    );

endmodule

// File: tb/tb_mac16_dot_seq.sv
// Bench for mac16_dot_seq: two instances (MAC_LAT 0 and 2), each driving a
// behavioural signed MAC16 accumulator model.
module tb_mac16_dot_seq;

    localparam int NU    = 2;
    localparam int LEN_W = 12;
    localparam int BOUND = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             cmd_valid [NU];
    logic             cmd_ready [NU];
    logic [LEN_W-1:0] cmd_len   [NU];
    logic             s_valid   [NU];
    logic             s_ready   [NU];
    logic [15:0]      s_a       [NU];
    logic [15:0]      s_b       [NU];
    logic             r_valid   [NU];
    logic             r_ready   [NU];
    logic [31:0]      r_data    [NU];
    logic [15:0]      mac_a     [NU];
    logic [15:0]      mac_b     [NU];
    logic             mac_oload [NU];
    logic             mac_ohold [NU];
    logic [31:0]      mac_o     [NU];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < NU; g++) begin : g_u
        localparam int LAT = (g == 0) ? 0 : 2;

        mac16_dot_seq #(
            .LEN_W   (LEN_W),
            .MAC_LAT (LAT)
        ) dut (
            .CLK       (clk),
            .RST       (rst),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .cmd_len   (cmd_len[g]),
            .s_valid   (s_valid[g]),
            .s_ready   (s_ready[g]),
            .s_a       (s_a[g]),
            .s_b       (s_b[g]),
            .r_valid   (r_valid[g]),
            .r_ready   (r_ready[g]),
            .r_data    (r_data[g]),
            .mac_a     (mac_a[g]),
            .mac_b     (mac_b[g]),
            .mac_oload (mac_oload[g]),
            .mac_ohold (mac_ohold[g]),
            .mac_o     (mac_o[g])
        );

        // Tile model: LAT operand registers, signed multiply, accumulator with
        // OLOAD (C/D tied to zero) and OHOLD; never reset, starts with garbage.
        logic [15:0]        ea, eb;
        logic signed [31:0] prod;
        logic [31:0]        acc = 32'h1234_5678;

        if (LAT == 0) begin : g_l0
            assign ea = mac_a[g];
            assign eb = mac_b[g];
        end else begin : g_ln
            logic [47:0] sa = '0;
            logic [47:0] sb = '0;
            always @(posedge clk) begin
                sa <= {sa[31:0], mac_a[g]};
                sb <= {sb[31:0], mac_b[g]};
            end
            assign ea = sa[16*LAT-1 -: 16];
            assign eb = sb[16*LAT-1 -: 16];
        end

        assign prod = $signed(ea) * $signed(eb);

        always @(posedge clk) begin
            if (mac_oload[g])       acc <= '0;
            else if (!mac_ohold[g]) acc <= acc + prod;
        end
        assign mac_o[g] = acc;
    end

    typedef struct {
        int          u;
        int          len;
        logic [63:0] a;
        logic [63:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    function automatic int lat_of(input int u);
        return (u == 0) ? 0 : 2;
    endfunction

    function automatic bit stall_pat(input int n);
        return (n == 2) || (n == 5) || (n == 8) || (n == 11);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no response within %0d cycles", name, BOUND);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_idle(input int u, input string name);
        check({name, ".ctl"}, 32'({cmd_ready[u], s_ready[u], r_valid[u], mac_oload[u], mac_ohold[u]}),
              32'b10001);
        check({name, ".r_data"}, r_data[u], 32'h0);
        check({name, ".mac_ab"}, {mac_a[u], mac_b[u]}, 32'h0);
    endtask

    task automatic send_cmd(input int u, input int len);
        int n = 0;
        cmd_len[u]   = LEN_W'(len);
        cmd_valid[u] = 1'b1;
        while (!cmd_ready[u] && n < BOUND) begin
            step();
            n++;
        end
        if (!cmd_ready[u]) timeout("cmd_ready");
        step();
        cmd_valid[u] = 1'b0;
    endtask

    task automatic send_beat(input int u, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        s_a[u]     = a;
        s_b[u]     = b;
        s_valid[u] = 1'b1;
        while (!s_ready[u] && n < BOUND) begin
            step();
            n++;
        end
        if (!s_ready[u]) timeout("s_ready");
        step();
        s_valid[u] = 1'b0;
    endtask

    task automatic wait_result(input int u, output int edges, output logic sr_seen);
        edges   = 0;
        sr_seen = s_ready[u];
        while (!r_valid[u] && edges < BOUND) begin
            step();
            edges++;
            sr_seen = sr_seen | s_ready[u];
        end
        if (!r_valid[u]) timeout("r_valid");
    endtask

    task automatic take_result(input int u);
        r_ready[u] = 1'b1;
        step();
        r_ready[u] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          edges;
        logic        sr_seen;
        logic        flag;
        logic [15:0] got_ld, got_oh, got_rv, exp_ld, exp_oh, exp_rv;

        for (int u = 0; u < NU; u++) begin
            cmd_valid[u] = 1'b0;
            cmd_len[u]   = '0;
            s_valid[u]   = 1'b0;
            s_a[u]       = '0;
            s_b[u]       = '0;
            r_ready[u]   = 1'b0;
        end

        // Pair i sits in bits [63-16*i -: 16]; listed left to right as pair 0..3.
        vecs[0] = '{u: 0, len: 3, a: {16'd3, 16'd5, 16'hFFFE, 16'd0},
                    b: {16'd4, 16'd6, 16'd7, 16'd0}, exp: 32'h0000_001C};
        vecs[1] = '{u: 0, len: 1, a: {16'hFFFF, 48'd0},
                    b: {16'hFFFF, 48'd0}, exp: 32'h0000_0001};
        vecs[2] = '{u: 0, len: 2, a: {16'h8000, 16'h8000, 32'd0},
                    b: {16'h8000, 16'h8000, 32'd0}, exp: 32'h8000_0000};
        vecs[3] = '{u: 1, len: 3, a: {16'd100, 16'd7, 16'd0, 16'd0},
                    b: {16'hFFFD, 16'd7, 16'd123, 16'd0}, exp: 32'hFFFF_FF05};
        vecs[4] = '{u: 1, len: 0, a: 64'd0, b: 64'd0, exp: 32'h0};
        vecs[5] = '{u: 0, len: 0, a: 64'd0, b: 64'd0, exp: 32'h0};
        vecs[6] = '{u: 1, len: 1, a: {16'h7FFF, 48'd0},
                    b: {16'h8000, 48'd0}, exp: 32'hC000_8000};

        step();
        step();
        check_idle(0, "reset.u0");
        check_idle(1, "reset.u1");
        rst = 1'b0;
        step();

        // Table: r_valid follows the last beat by MAC_LAT+2 edges, or the
        // command edge by MAC_LAT+3 edges when cmd_len is zero.
        for (int i = 0; i < NV; i++) begin
            int u;
            u = vecs[i].u;
            send_cmd(u, vecs[i].len);
            for (int j = 0; j < vecs[i].len; j++) begin
                send_beat(u, vecs[i].a[63-16*j -: 16], vecs[i].b[63-16*j -: 16]);
            end
            wait_result(u, edges, sr_seen);
            check($sformatf("vec%0d.latency", i), 32'(edges),
                  32'(lat_of(u) + ((vecs[i].len == 0) ? 3 : 2)));
            check($sformatf("vec%0d.r_data", i), r_data[u], vecs[i].exp);
            if (vecs[i].len == 0) check($sformatf("vec%0d.s_ready", i), 32'(sr_seen), 32'd0);
            take_result(u);
            step();
        end

        // MAC_LAT=2 with s_valid pattern 1-0-0-1...: the token seen after edge
        // e+m is the one injected at edge e+m-2.
        send_cmd(1, 4);
        got_ld = '0; got_oh = '0; got_rv = '0;
        exp_ld = '0; exp_oh = '0; exp_rv = '0;
        for (int m = 1; m <= 15; m++) begin
            s_a[1]     = 16'h7FFF;
            s_b[1]     = 16'h7FFF;
            s_valid[1] = stall_pat(m);
            step();
            got_ld[m] = mac_oload[1];
            got_oh[m] = mac_ohold[1];
            got_rv[m] = r_valid[1];
            exp_ld[m] = (m - 2 == 1);
            exp_oh[m] = !((m - 2 == 1) || stall_pat(m - 2));
            exp_rv[m] = (m == 15);
        end
        s_valid[1] = 1'b0;
        check("stall.oload", 32'(got_ld), 32'(exp_ld));
        check("stall.ohold", 32'(got_oh), 32'(exp_oh));
        check("stall.r_valid", 32'(got_rv), 32'(exp_rv));
        check("stall.mac_a", 32'(mac_a[1]), 32'h7FFF);
        check("stall.r_data", r_data[1], 32'hFFFC_0004);
        take_result(1);
        step();

        // Back-to-back: second command waits behind a stalled result.
        send_cmd(0, 2);
        send_beat(0, 16'd1, 16'd1);
        send_beat(0, 16'd2, 16'd2);
        wait_result(0, edges, sr_seen);
        check("b2b.first", r_data[0], 32'd5);
        cmd_len[0]   = LEN_W'(1);
        cmd_valid[0] = 1'b1;
        flag    = 1'b1;
        sr_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            flag    = flag & r_valid[0] & (r_data[0] == 32'd5);
            sr_seen = sr_seen | cmd_ready[0];
        end
        check("b2b.held", 32'(flag), 32'd1);
        check("b2b.cmd_ready_busy", 32'(sr_seen), 32'd0);
        take_result(0);
        check("b2b.cmd_ready_idle", 32'(cmd_ready[0]), 32'd1);
        step();
        cmd_valid[0] = 1'b0;
        send_beat(0, 16'd3, 16'd3);
        wait_result(0, edges, sr_seen);
        check("b2b.second", r_data[0], 32'd9);
        take_result(0);
        step();

        // Asynchronous reset in the middle of a 5-beat command.
        send_cmd(1, 5);
        send_beat(1, 16'd10, 16'd10);
        send_beat(1, 16'd20, 16'd20);
        check("rst.pre_mac_a", 32'(mac_a[1]), 32'd20);
        #2;
        rst = 1'b1;
        #1;
        check_idle(1, "rst.mid");
        step();
        step();
        rst     = 1'b0;
        flag    = 1'b1;
        sr_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            sr_seen = sr_seen | r_valid[1];
            flag    = flag & cmd_ready[1];
        end
        check("rst.no_result", 32'(sr_seen), 32'd0);
        check("rst.idle", 32'(flag), 32'd1);
        send_cmd(1, 1);
        send_beat(1, 16'd2, 16'd3);
        wait_result(1, edges, sr_seen);
        check("rst.latency", 32'(edges), 32'd4);
        check("rst.r_data", r_data[1], 32'd6);
        take_result(1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
